// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: control states and
// helper for sizing bit-cycle counters.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must be able to hold 0..width inclusive.
    function automatic int unsigned count_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_fsub.sv
// Single-bit full subtractor built from two cascaded half subtractors.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    assign d1   = x ^ y;
    assign b1   = ~x & y;
    assign d    = d1 ^ bin;
    assign b2   = ~d1 & bin;
    assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B: LSB first, one bit per clock through one full subtractor
// and a borrow flip-flop; parallel load on start, parallel result with done.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bor_q, bor_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             d_bit;
    logic             b_next;

    full_subtractor u_fsub (
        .x   (a_sh_q[0]),
        .y   (b_sh_q[0]),
        .bin (bor_q),
        .d   (d_bit),
        .bout(b_next)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        d_sh_d   = d_sh_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        bor_d    = bor_q;
        borrow_d = borrow_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                d_sh_d = {d_bit, d_sh_q[WIDTH-1:1]};
                bor_d  = b_next;
                cnt_d  = cnt_q + CW'(1);
                // Final bit goes straight to diff so the result lands on this edge.
                if (cnt_q == LAST) begin
                    diff_d   = {d_bit, d_sh_q[WIDTH-1:1]};
                    borrow_d = b_next;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == BUSY);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            d_sh_q   <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bor_q    <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            d_sh_q   <= d_sh_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            bor_q    <= bor_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bw;
        int unsigned  at;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int unsigned  checks = 0;
    int unsigned  passes = 0;
    int unsigned  cyc = 0;
    exp_t         exp_q[$];
    logic [W-1:0] held_diff = '0;
    logic         held_bor = 1'b0;
    logic         prev_done = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrow_out(borrow_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                check("done_one_cycle", {31'd0, prev_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("diff", 32'(diff), 32'(e.d));
                    check("borrow_out", {31'd0, borrow_out}, {31'd0, e.bw});
                    check("latency", cyc, e.at);
                    held_diff = e.d;
                    held_bor  = e.bw;
                end
            end else begin
                check("diff_hold", 32'(diff), 32'(held_diff));
                check("borrow_hold", {31'd0, borrow_out}, {31'd0, held_bor});
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one operation; optionally pulse a stray start on busy cycle 3, or
    // assert reset during busy cycle rst_at (0 = no reset). Returns in DONE.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input bit stray, input int unsigned rst_at);
        exp_t e;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        e.d  = av - bv;
        e.bw = (av < bv);
        e.at = cyc + W;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        for (int unsigned i = 1; i <= W; i++) begin
            check("busy_high", {31'd0, busy}, 32'd1);
            check("done_low", {31'd0, done}, 32'd0);
            if (stray && i == 3) begin
                start = 1'b1; a = W'(1); b = W'(1);
            end else begin
                start = 1'b0;
            end
            if (rst_at == i) begin
                #2 rst = 1'b1;
                #1;
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_done", {31'd0, done}, 32'd0);
                check("rst_diff", 32'(diff), 32'd0);
                check("rst_borrow", {31'd0, borrow_out}, 32'd0);
                exp_q.delete();
                held_diff = '0;
                held_bor  = 1'b0;
                start = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (i < W) @(negedge clk);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_borrow", {31'd0, borrow_out}, 32'd0);
        idle(2);
        rst = 1'b0;

        run_op(W'(9), W'(3), 1'b0, 0);
        idle(2);
        run_op(W'(3), W'(9), 1'b0, 0);
        idle(1);
        run_op(W'(8'h00), W'(8'hFF), 1'b0, 0);
        run_op(W'(8'hA5), W'(8'hA5), 1'b0, 0);
        idle(1);
        run_op(W'(100), W'(40), 1'b1, 0);
        idle(2);
        run_op(W'(55), W'(77), 1'b0, 2);
        run_op(W'(200), W'(13), 1'b0, 0);
        for (int n = 0; n < 40; n++) begin
            run_op(W'($urandom), W'($urandom), bit'($urandom_range(1)), 0);
            if ($urandom_range(1) == 1) idle($urandom_range(1, 3));
        end
        idle(3);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor: computes A - B, LSB-first, one bit per clock, using a single full-subtractor cell and a borrow flip-flop.
- Arithmetic counterpart of the half_adder_df datapath cell; the first sequential arithmetic block in the BEGIN library.
- Parallel load on start; parallel result with a one-cycle done pulse after WIDTH bit-cycles.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a subtraction; sampled on the rising clk edge.
- a  input  WIDTH  minuend; captured when start is accepted.
- b  input  WIDTH  subtrahend; captured when start is accepted.
- busy  output  1  high while bit-cycles are in progress.
- done  output  1  one-cycle pulse: result valid.
- diff  output  WIDTH  (a - b) mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 when a < b (unsigned).

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, diff=0, borrow_out=0; internal shift registers, count and borrow cleared. Reset mid-operation abandons the operation with no done pulse.
- States: IDLE, BUSY, DONE (encoding from the shared package).
- IDLE or DONE, start=1 at edge k:
  - load a_sh<=a, b_sh<=b, bor<=0, count<=0;
  - state->BUSY, busy=1.
- IDLE, start=0: stay in IDLE.
- DONE, start=0: go to IDLE; done drops.
- BUSY, each edge, with bit inputs x=a_sh[0], y=b_sh[0]:
  - d = x ^ y ^ bor;
  - bor_next = (~x & y) | (~(x ^ y) & bor);
  - a_sh and b_sh shift right; d shifts into the MSB of d_sh; count++.
- On the WIDTH-th BUSY edge (edge k+WIDTH):
  - diff <= final shifted value; borrow_out <= bor_next;
  - state->DONE, busy=0, done=1.
  - done stays high for exactly one cycle unless a start is accepted on edge k+WIDTH+1. In that case done still falls and busy rises.
- Latency: start sampled at edge k; result and done visible after edge k+WIDTH.
- start while BUSY: ignored. The operation is not restarted and the a/b inputs are not re-captured.
- diff and borrow_out hold their last values until the next completion or reset. They do not change during BUSY.
- count width is clog2(WIDTH+1).
- Boundary cases:
  - a == b gives diff=0, borrow_out=0.
  - a=0, b=2^WIDTH-1 gives diff=1, borrow_out=1.
- Single always block for state; no combinational path from start to busy/done (all outputs registered).

Decomposition:
- Package serial_arith_pkg holds the state enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the shared function for count width.
- Sub-module full_subtractor (inputs x, y, bin; outputs d, bout), purely combinational. It is built from two half-subtractor equations and instantiated once in the datapath.

Test Plan:
- WIDTH=4; reset, then start with a=9, b=3 -> busy high for 4 cycles; done pulse after the 4th edge; diff=4'd6, borrow_out=0.
- WIDTH=4; a=3, b=9 -> diff=4'hA, borrow_out=1; done lasts exactly one cycle.
- WIDTH=8; a=8'h00, b=8'hFF -> diff=8'h01, borrow_out=1. Also a=b=8'hA5 -> diff=0, borrow_out=0.
- WIDTH=8; start a=100, b=40, then pulse start with a=1, b=1 on cycle 3 of BUSY -> second start ignored; result diff=60.
- Assert rst on BUSY cycle 2 -> busy, done, diff and borrow_out go to 0 immediately (asynchronously); no done pulse. A new start afterwards yields the correct result.
- Back-to-back: start asserted in the DONE cycle -> new operation accepted; done falls and busy rises on the same edge.
